// File: rtl/elevator_request_scheduler_pkg.sv
// Shared elevator definitions: car state encoding and width helpers.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction

  function automatic int floor_w(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Request inputs and car status outputs of the scheduler.
interface elevator_request_scheduler_if
  import elevator_pkg::*;
#(
  parameter int N_FLOORS = 4,
  parameter int FLOOR_W  = floor_w(N_FLOORS)
) ();

  logic [N_FLOORS-1:0] req_pulse;
  logic                door_hold;
  logic [FLOOR_W-1:0]  current_floor;
  logic [N_FLOORS-1:0] pending;
  logic                dir_up;
  logic                moving;
  logic                door_open;

  modport master (
    output req_pulse, door_hold,
    input  current_floor, pending, dir_up, moving, door_open
  );

  modport slave (
    input  req_pulse, door_hold,
    output current_floor, pending, dir_up, moving, door_open
  );

endinterface

// File: rtl/elevator_request_scheduler_cycle_timer.sv
// Loadable down-counter; o_term flags the last cycle of a period.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_term
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_term = (r_count == W'(1));

endmodule

// File: rtl/elevator_request_scheduler.sv
// LOOK-order car scheduler: latches floor requests, times travel and door.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int N_FLOORS      = 4,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4
) (
  input logic clk,
  input logic rst,
  elevator_request_scheduler_if.slave bus
);

  localparam int FW = floor_w(N_FLOORS);
  localparam int TMAX =
    (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW = clog2(TMAX + 1);
  localparam logic [TW-1:0] L_TRAV = TW'(TRAVEL_CYCLES);
  localparam logic [TW-1:0] L_DOOR = TW'(DOOR_CYCLES);
  localparam logic [FW-1:0] L_TOP  = FW'(N_FLOORS - 1);
  localparam logic [N_FLOORS-1:0] L_ONE = N_FLOORS'(1);

  state_t              r_state;
  logic [FW-1:0]       r_floor;
  logic [N_FLOORS-1:0] r_pend;
  logic                r_dir;

  logic [FW-1:0]       w_next_floor;
  logic [N_FLOORS-1:0] w_above;
  logic [N_FLOORS-1:0] w_below;
  logic [N_FLOORS-1:0] w_req;
  logic [N_FLOORS-1:0] w_clr;
  logic                w_term;
  logic                w_load;
  logic [TW-1:0]       w_load_val;
  logic                w_open;
  logic                w_up;
  logic                w_down;
  logic                w_close;

  cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (1'b1),
    .o_term     (w_term)
  );

  // Floor index saturates at the shaft ends.
  always_comb begin
    w_next_floor = r_floor;
    if (r_state == MOVE_UP && r_floor != L_TOP)
      w_next_floor = r_floor + 1'b1;
    else if (r_state == MOVE_DOWN && r_floor != '0)
      w_next_floor = r_floor - 1'b1;
  end

  always_comb begin
    w_above = '0;
    w_below = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (i > int'(r_floor)) w_above[i] = r_pend[i];
      if (i < int'(r_floor)) w_below[i] = r_pend[i];
    end
  end

  // A call for the floor whose door is open only extends the dwell.
  assign w_req = bus.req_pulse
    & ~((r_state == DOOR_OPEN) ? (L_ONE << r_floor) : '0);

  always_comb begin
    w_load     = 1'b0;
    w_load_val = L_TRAV;
    w_clr      = '0;
    w_open     = 1'b0;
    w_up       = 1'b0;
    w_down     = 1'b0;
    w_close    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_pend[r_floor]) w_open = 1'b1;
        else if (|w_above && (r_dir || ~|w_below)) w_up = 1'b1;
        else if (|w_below) w_down = 1'b1;
      end
      MOVE_UP, MOVE_DOWN: begin
        if (w_term) begin
          if (r_pend[w_next_floor]) w_open = 1'b1;
          else w_load = 1'b1;
        end
      end
      DOOR_OPEN: begin
        if (bus.door_hold || bus.req_pulse[r_floor]) begin
          w_load     = 1'b1;
          w_load_val = L_DOOR;
        end else if (w_term) begin
          w_close = 1'b1;
        end
      end
    endcase
    if (w_open) begin
      w_load     = 1'b1;
      w_load_val = L_DOOR;
      w_clr      = L_ONE << w_next_floor;
    end
    if (w_up || w_down) w_load = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_floor <= '0;
      r_pend  <= '0;
      r_dir   <= 1'b1;
    end else begin
      r_pend <= (r_pend | w_req) & ~w_clr;
      unique case (r_state)
        IDLE: begin
          if (w_open) begin
            r_state <= DOOR_OPEN;
          end else if (w_up) begin
            r_state <= MOVE_UP;
            r_dir   <= 1'b1;
          end else if (w_down) begin
            r_state <= MOVE_DOWN;
            r_dir   <= 1'b0;
          end
        end
        MOVE_UP, MOVE_DOWN: begin
          if (w_term) begin
            r_floor <= w_next_floor;
            if (w_open) r_state <= DOOR_OPEN;
          end
        end
        DOOR_OPEN: begin
          if (w_close) r_state <= IDLE;
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst)
    !(w_term && ((r_state == MOVE_UP && r_floor == L_TOP) ||
                 (r_state == MOVE_DOWN && r_floor == '0))));

  assign bus.current_floor = r_floor;
  assign bus.pending       = r_pend;
  assign bus.dir_up        = r_dir;
  assign bus.moving        = (r_state == MOVE_UP) || (r_state == MOVE_DOWN);
  assign bus.door_open     = (r_state == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scoreboard bench: behavioural car model predicts outputs every cycle.
module tb_elevator_request_scheduler;

  localparam int NF = 4;
  localparam int TRV = 8;
  localparam int DWL = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elevator_request_scheduler_if #(.N_FLOORS(NF)) bus ();

  elevator_request_scheduler #(
    .N_FLOORS(NF), .TRAVEL_CYCLES(TRV), .DOOR_CYCLES(DWL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int fl; int pend; int dir; int mov; int door;
  } exp_t;

  typedef enum {M_IDLE, M_UP, M_DOWN, M_DOOR} mst_e;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  mst_e m_st;
  int   m_fl, m_tmr, m_dir;
  bit   m_pend[NF];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void m_reset();
    m_st = M_IDLE; m_fl = 0; m_tmr = 0; m_dir = 1;
    foreach (m_pend[i]) m_pend[i] = 0;
  endfunction

  function automatic int m_pvec();
    int v = 0;
    foreach (m_pend[i]) if (m_pend[i]) v += (1 << i);
    return v;
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    e.fl = m_fl; e.pend = m_pvec(); e.dir = m_dir;
    e.mov = (m_st == M_UP || m_st == M_DOWN) ? 1 : 0;
    e.door = (m_st == M_DOOR) ? 1 : 0;
    return e;
  endfunction

  // One clock edge of the car, written from the service rules.
  function automatic void m_step(input bit [NF-1:0] req, input bit hold);
    bit up_req = 0, dn_req = 0;
    int serve = -1;
    mst_e st0 = m_st;
    int fl0 = m_fl;
    for (int i = 0; i < NF; i++) begin
      if (m_pend[i] && i > m_fl) up_req = 1;
      if (m_pend[i] && i < m_fl) dn_req = 1;
    end
    case (m_st)
      M_IDLE: begin
        if (m_pend[m_fl]) begin
          serve = m_fl; m_st = M_DOOR; m_tmr = DWL;
        end else if (up_req && (m_dir == 1 || !dn_req)) begin
          m_st = M_UP; m_dir = 1; m_tmr = TRV;
        end else if (dn_req) begin
          m_st = M_DOWN; m_dir = 0; m_tmr = TRV;
        end
      end
      M_UP, M_DOWN: begin
        if (m_tmr == 1) begin
          m_fl = (m_st == M_UP) ? m_fl + 1 : m_fl - 1;
          if (m_pend[m_fl]) begin
            serve = m_fl; m_st = M_DOOR; m_tmr = DWL;
          end else m_tmr = TRV;
        end else m_tmr--;
      end
      M_DOOR: begin
        if (hold || req[m_fl]) m_tmr = DWL;
        else if (m_tmr == 1) begin m_st = M_IDLE; m_tmr = 0; end
        else m_tmr--;
      end
    endcase
    for (int i = 0; i < NF; i++) begin
      if (req[i] && !(st0 == M_DOOR && i == fl0)) m_pend[i] = 1;
      if (i == serve) m_pend[i] = 0;
    end
  endfunction

  task automatic tick(input bit [NF-1:0] r, input bit h);
    bus.req_pulse = r;
    bus.door_hold = h;
    @(posedge clk);
    m_step(r, h);
    q.push_back(m_out());
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick('0, 1'b0);
  endtask

  task automatic run_to_floor(input int f, input int budget);
    int n = 0;
    while (m_fl != f && n < budget) begin tick('0, 1'b0); n++; end
    chk("wait_floor", int'(bus.current_floor), f);
  endtask

  task automatic run_to_door(input int budget);
    int n = 0;
    while (m_st != M_DOOR && n < budget) begin tick('0, 1'b0); n++; end
    chk("wait_door", int'(bus.door_open), 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_floor"}, int'(bus.current_floor), 0);
    chk({tag, "_pend"}, int'(bus.pending), 0);
    chk({tag, "_dir"}, int'(bus.dir_up), 1);
    chk({tag, "_moving"}, int'(bus.moving), 0);
    chk({tag, "_door"}, int'(bus.door_open), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0 && !rst) begin
        e = q.pop_front();
        chk("floor", int'(bus.current_floor), e.fl);
        chk("pending", int'(bus.pending), e.pend);
        chk("dir_up", int'(bus.dir_up), e.dir);
        chk("moving", int'(bus.moving), e.mov);
        chk("door_open", int'(bus.door_open), e.door);
      end
    end
  end

  initial begin : stim
    rst = 1'b1;
    bus.req_pulse = '0;
    bus.door_hold = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst_init");
    rst = 1'b0;

    // Request at the current floor: door cycle.
    tick(4'b0001, 1'b0);
    idle(8);

    // Travel to the top floor.
    tick(4'b1000, 1'b0);
    idle(40);

    // Back to floor 0, then up with intermediate and reverse calls.
    tick(4'b0001, 1'b0);
    idle(40);
    tick(4'b1000, 1'b0);
    idle(3);
    tick(4'b0010, 1'b0);
    run_to_floor(2, 60);
    tick(4'b0001, 1'b0);
    idle(70);

    // Door hold at floor 2, then same-floor call while open.
    tick(4'b0100, 1'b0);
    run_to_door(40);
    for (int i = 0; i < 10; i++) tick('0, 1'b1);
    idle(2);
    tick(4'b0100, 1'b0);
    idle(10);

    // Asynchronous reset while travelling up.
    tick(4'b0001, 1'b0);
    idle(30);
    tick(4'b1000, 1'b0);
    run_to_floor(1, 40);
    #5;
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    m_reset();
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(20);

    for (int i = 0; i < 1200; i++) begin
      bit [NF-1:0] r;
      bit h;
      r = ($urandom_range(0, 5) == 0) ? NF'($urandom_range(1, 15)) : '0;
      h = ($urandom_range(0, 11) == 0);
      tick(r, h);
    end
    idle(60);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
